seq_shift_add_mult_32: RTL and testbench



---
 rtl/seq_shift_add_mult_32.sv | 98 +++++++++
 tb/tb_seq_shift_add_mult_32.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult_32.sv
// Iterative 32x32 unsigned shift-and-add multiplier with valid/ready handshakes,
// built around a 32-bit carry-select adder that does one partial-product add per cycle.

module carry_select_adder_32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [4:0] carry;

  assign carry[0] = cin;

  // Each 8-bit block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [8:0] r0;
    logic [8:0] r1;
    assign r0 = {1'b0, in1[8*g +: 8]} + {1'b0, in2[8*g +: 8]};
    assign r1 = r0 + 9'd1;
    assign sum[8*g +: 8] = carry[g] ? r1[7:0] : r0[7:0];
    assign carry[g+1]    = carry[g] ? r1[8]   : r0[8];
  end

  assign cout = carry[4];
endmodule

module seq_shift_add_mult_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] s;
  logic             c;

  carry_select_adder_32 u_add (
    .in1  (p_hi),
    .in2  (a),
    .cin  (1'b0),
    .sum  (s),
    .cout (c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= mcand;
            p_hi  <= '0;
            p_lo  <= mplier;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // The adder carry-out shifts into the top of P_hi, so no product bit is lost.
          if (p_lo[0]) {p_hi, p_lo} <= {c, s, p_lo[WIDTH-1:1]};
          else         {p_hi, p_lo} <= {1'b0, p_hi, p_lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign product   = {p_hi, p_lo};
endmodule

// File: tb/tb_seq_shift_add_mult_32.sv
// Directed and randomized checks of seq_shift_add_mult_32 against a 64-bit multiply model.

module tb_seq_shift_add_mult_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  seq_shift_add_mult_32 #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, time the latency, optionally stall the handoff and
  // inject ignored operands (junk) while BUSY and DONE.
  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                        input logic [63:0] exp, input int unsigned stall,
                        input bit junk, input string tag);
    int unsigned k;
    bit seen;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    mcand = opa; mplier = opb; in_valid = 1'b1; out_ready = junk;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ":busy"}, 64'(busy), 64'd1);
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (junk) begin
        in_valid = 1'b1; mcand = ~opa; mplier = opb ^ 32'h5A5A_0F0F;
      end
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (junk) chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!seen) k = 99;
    chk({tag, ":latency"}, 64'(k), 64'd32);
    chk({tag, ":product"}, product, exp);
    for (int unsigned st = 0; st < stall; st++) begin
      if (junk) begin
        in_valid = 1'b1; mcand = 32'hDEAD_0001; mplier = 32'h0000_0003;
      end
      @(negedge clk);
      if (junk) begin
        chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ":hold_product"}, product, exp);
        chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":handoff_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ":handoff_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ":product_kept"}, product, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    #12;
    chk("reset_product", product, 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, "3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0, "max");
    run_op(32'h1234_5678, 32'h0, 64'd0, 0, 1'b0, "mplier0");
    run_op(32'h0, 32'hDEAD_BEEF, 64'd0, 0, 1'b0, "mcand0");
    run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 10, 1'b1, "stall");

    // Abort mid-operation: reset acts without a clock edge.
    mcand = 32'hAAAA_AAAA; mplier = 32'h5555_5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd7, 32'd9, 64'd63, 0, 1'b0, "after_abort");

    for (int unsigned i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: ra = 32'h8000_0000;
        1: rb = 32'h0000_0001;
        2: begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
        3: ra = 32'h0000_0001;
        default: ;
      endcase
      run_op(ra, rb, 64'(ra) * 64'(rb), $urandom_range(0, 3), 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
